// File: rtl/apb_master_bridge_pkg.sv
// Shared APB widths, master FSM state encoding and command record for apb_master_bridge.
package apb_master_bridge_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } apb_cmd_t;

  // Reads never carry byte strobes on an APB4 bus.
  function automatic apb_cmd_t pack_cmd(input logic                  write,
                                        input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [DATA_WIDTH-1:0] wdata,
                                        input logic [STRB_WIDTH-1:0] strb);
    apb_cmd_t c;
    c.write = write;
    c.addr  = addr;
    c.wdata = wdata;
    c.strb  = write ? strb : '0;
    return c;
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter for apb_master_bridge; only built when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the last permitted stalled ACCESS cycle; the FSM leaves ACCESS on it.
  assign expire = tick && (cnt == LAST);

endmodule
`endif

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB4 SETUP/ACCESS transfer bridge, one transfer outstanding.
// Optional ACCESS timeout abort enabled with `define APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | bus idle, cmd_ready high
// SETUP  | PSELx=1, PENABLE=0, one cycle
// ACCESS | PSELx=1, PENABLE=1, waiting for PREADY
// RESP   | rsp_valid high until rsp_ready
module apb_master_bridge
  import apb_master_bridge_pkg::*;
`ifdef APB_TIMEOUT_EN
  #(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
  (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  apb_mst_state_e state;
  apb_cmd_t       cmd_in;
  logic           timeout_hit;

  assign cmd_in    = pack_cmd(cmd_write, cmd_addr, cmd_wdata, cmd_strb);
  assign cmd_ready = (state == IDLE) && PRESETn;

`ifdef APB_TIMEOUT_EN
  apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clear (state == SETUP),
    .tick  ((state == ACCESS) && !PREADY),
    .expire(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE  <= cmd_in.write;
            PADDR   <= cmd_in.addr;
            PWDATA  <= cmd_in.wdata;
            PSTRB   <= cmd_in.strb;
            PSELx   <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY has priority over a timeout landing on the same cycle.
          if (PREADY) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            rsp_valid <= 1'b1;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed APB cases, random traffic, reset abort.
module tb_apb_master_bridge;
  import apb_master_bridge_pkg::*;

  logic                  PCLK = 1'b0;
  logic                  PRESETn = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic                  cmd_write = 1'b0;
  logic [ADDR_WIDTH-1:0] cmd_addr = '0;
  logic [DATA_WIDTH-1:0] cmd_wdata = '0;
  logic [STRB_WIDTH-1:0] cmd_strb = '0;
  logic                  PSELx, PENABLE, PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY = 1'b0;
  logic [DATA_WIDTH-1:0] PRDATA = '0;
  logic                  PSLVERR = 1'b0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  apb_master_bridge dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 PCLK = ~PCLK;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  // Reference register file (model) and the slave's own storage.
  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Caller is at a negedge with the bridge idle; returns at a negedge with the bridge idle.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input int rdly,
                         input bit noise);
    logic [31:0] exp_rd, err_pat;
    logic [3:0]  exp_strb;
    bit          exp_err, s_err;
    int          idx;
    idx      = int'(addr[5:2]);
    err_pat  = $urandom;
    exp_err  = !(addr < 32'h40);
    exp_strb = wr ? strb : 4'h0;
    if (wr) exp_rd = 32'h0;
    else if (exp_err) exp_rd = err_pat;
    else exp_rd = ref_mem[idx];
    if (wr && !exp_err) ref_mem[idx] = merge(ref_mem[idx], wdata, strb);

    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    @(negedge PCLK);
    if (noise) begin
      cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'hF;
    end else cmd_valid = 0;
    chk("setup_psel", PSELx, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_paddr", PADDR, addr);
    chk("setup_pwdata", PWDATA, wdata);
    chk("setup_pstrb", PSTRB, exp_strb);
    chk("setup_cmd_ready", cmd_ready, 0);

    for (int k = 0; k <= waits; k++) begin
      @(negedge PCLK);
      chk("acc_psel", PSELx, 1);
      chk("acc_penable", PENABLE, 1);
      chk("acc_paddr", PADDR, addr);
      chk("acc_pwdata", PWDATA, wdata);
      chk("acc_pstrb", PSTRB, exp_strb);
      chk("acc_rsp_valid", rsp_valid, 0);
      if (k < waits) begin
        PREADY = 0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      end else begin
        s_err   = !(PADDR < 32'h40);
        PREADY  = 1;
        PSLVERR = s_err;
        if (PWRITE) PRDATA = $urandom;
        else PRDATA = s_err ? err_pat : slv_mem[int'(PADDR[5:2])];
        if (PWRITE && !s_err)
          slv_mem[int'(PADDR[5:2])] = merge(slv_mem[int'(PADDR[5:2])], PWDATA, PSTRB);
      end
    end

    @(negedge PCLK);
    PREADY = 0; PSLVERR = 0; PRDATA = $urandom;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", rsp_err, exp_err);
    chk("resp_psel", PSELx, 0);
    chk("resp_penable", PENABLE, 0);
    chk("resp_paddr_hold", PADDR, addr);
    chk("resp_cmd_ready", cmd_ready, 0);
    for (int d = 0; d < rdly; d++) begin
      @(negedge PCLK);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(negedge PCLK);
    rsp_ready = 0;
    cmd_valid = 0;
    chk("done_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_psel", PSELx, 0);
    chk("done_paddr_hold", PADDR, addr);
  endtask

  initial begin
    bit          acc_done;
    int          n;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = 32'h0; slv_mem[i] = 32'h0; end

    #3;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", PSELx, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", PSTRB, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge PCLK); @(negedge PCLK);
    PRESETn = 1;
    @(negedge PCLK);

    do_xfer(1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_xfer(0, 32'h08, 32'h0, 4'hF, 0, 0, 0);
    do_xfer(1, 32'h0C, 32'h12345678, 4'h5, 3, 0, 0);
    do_xfer(0, 32'h100, 32'h0, 4'h0, 0, 0, 0);
    do_xfer(0, 32'h0C, 32'h0, 4'hA, 0, 0, 0);
    do_xfer(0, 32'h08, 32'h0, 4'h0, 0, 5, 1);
    do_xfer(1, 32'h3C, 32'hCAFEF00D, 4'h9, 15, 1, 0);
    do_xfer(0, 32'h3C, 32'h0, 4'h0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      a = {24'h0, 4'($urandom_range(0, 4)), 2'($urandom), 2'b00};
      do_xfer(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'($urandom));
    end

`ifdef APB_TIMEOUT_EN
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h04; cmd_wdata = '0; cmd_strb = '0;
    @(negedge PCLK);
    cmd_valid = 0;
    PREADY = 0;
    n = 0;
    acc_done = 0;
    for (int c = 0; c < 40 && !acc_done; c++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) acc_done = 1;
      else begin n++; PSLVERR = 1'($urandom); PRDATA = $urandom; end
    end
    PSLVERR = 0;
    chk("to_reached", acc_done, 1);
    chk("to_access_cycles", n, 16);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    rsp_ready = 1;
    @(negedge PCLK);
    rsp_ready = 0;
    chk("to_done_ready", cmd_ready, 1);
`endif

    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h55AA55AA; cmd_strb = 4'hF;
    @(negedge PCLK);
    cmd_valid = 0;
    PREADY = 0;
    @(negedge PCLK);
    chk("rst_mid_penable_before", PENABLE, 1);
    #2 PRESETn = 0;
    #1;
    chk("rst_mid_psel", PSELx, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 0);
    @(negedge PCLK);
    PRESETn = 1;
    repeat (3) begin
      @(negedge PCLK);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_psel", PSELx, 0);
    end
    do_xfer(0, 32'h10, 32'h0, 4'h0, 1, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
